// File: rtl/bus_router.sv
// bus_router: N-port address router from the CPU memory port to downstream bus translators.
// Optional feature macro: BUS_ROUTER_TIMEOUT_EN aborts a port transaction after TIMEOUT_CYCLES.
`ifndef PLEN
`define PLEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

package execute;
    typedef struct packed {
        logic       store;
        logic       fetch;
        logic [2:0] size;
    } memory_access_t;
endpackage

module bus_router #(
    parameter int                         NUM_PORTS      = 2,
    parameter logic [NUM_PORTS*`PLEN-1:0] BASE_ADDRS     = {`PLEN'(32'h0000_0000), `PLEN'(32'h8000_0000)},
    parameter logic [NUM_PORTS*`PLEN-1:0] ADDR_MASKS     = {`PLEN'(32'h8000_0000), `PLEN'(32'h8000_0000)},
    parameter int                         TIMEOUT_CYCLES = 1024
) (
    input  logic                                    i_clock,
    input  logic                                    i_reset,
    input  logic                                    i_mem_cycle,
    input  logic [`PLEN-1:0]                        i_mem_paddr,
    input  execute::memory_access_t                 i_mem_access,
    input  logic [`XLEN-1:0]                        i_mem_data_out,
    output logic [4*`XLEN-1:0]                      o_mem_data_in,
    output logic                                    o_mem_ack,
    output logic                                    o_mem_error,
    output logic [NUM_PORTS-1:0]                    o_port_cycle,
    output logic [NUM_PORTS*`PLEN-1:0]              o_port_paddr,
    output execute::memory_access_t [NUM_PORTS-1:0] o_port_access,
    output logic [NUM_PORTS*`XLEN-1:0]              o_port_data_out,
    input  logic [NUM_PORTS*4*`XLEN-1:0]            i_port_data_in,
    input  logic [NUM_PORTS-1:0]                    i_port_ack
);
    localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int DW    = 4 * `XLEN;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [NUM_PORTS-1:0]    r_port_cycle;
    logic [`PLEN-1:0]        r_paddr;
    execute::memory_access_t r_access;
    logic [`XLEN-1:0]        r_data_out;
    logic [SEL_W-1:0]        r_sel;
    logic                    r_err;
    logic [DW-1:0]           r_data;

    logic                    w_hit;
    logic [SEL_W-1:0]        w_hit_sel;
    logic [NUM_PORTS-1:0]    w_hit_vec;
    logic                    w_sel_ack;
    logic [DW-1:0]           w_sel_data;
    logic                    w_expire;
    logic                    w_accept;
    logic                    w_capture;
    logic [NUM_PORTS-1:0]    w_port_cycle_nxt;

    // Window decode of the live CPU address; scanning downward makes the lowest matching index win.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_sel = '0;
        w_hit_vec = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if ((i_mem_paddr & ADDR_MASKS[p*`PLEN +: `PLEN]) == BASE_ADDRS[p*`PLEN +: `PLEN]) begin
                w_hit     = 1'b1;
                w_hit_sel = SEL_W'(p);
                w_hit_vec = NUM_PORTS'(1) << p;
            end
        end
    end

    // Response mux: only the selected port's ack and read data are visible to the FSM.
    always_comb begin
        w_sel_ack  = 1'b0;
        w_sel_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_sel == SEL_W'(p)) begin
                w_sel_ack  = i_port_ack[p];
                w_sel_data = i_port_data_in[p*DW +: DW];
            end
        end
    end

`ifdef BUS_ROUTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] r_tmo;

    // Counts unacknowledged BUSY cycles; held at zero outside BUSY so each entry starts fresh.
    always_ff @(posedge i_clock) begin
        if (i_reset || r_state != S_BUSY)
            r_tmo <= '0;
        else if (!w_sel_ack)
            r_tmo <= r_tmo + 1'b1;
    end

    assign w_expire = (r_state == S_BUSY) && !w_sel_ack && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clock) begin
        r_state <= i_reset ? S_IDLE : w_state_nxt;
    end

    // Next state: decode in IDLE, wait for the selected ack or expiry in BUSY, single DONE cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_mem_cycle) w_state_nxt = w_hit ? S_BUSY : S_DONE;
            S_BUSY:  if (w_sel_ack || w_expire) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs and datapath strobes; port_cycle is computed here but only ever leaves through a flop.
    always_comb begin
        w_accept         = (r_state == S_IDLE) && i_mem_cycle;
        w_capture        = (r_state == S_BUSY) && w_sel_ack;
        w_port_cycle_nxt = (w_accept && w_hit) ? w_hit_vec :
                           (r_state == S_BUSY && !w_sel_ack && !w_expire) ? r_port_cycle : '0;
        o_mem_ack        = (r_state == S_DONE);
        o_mem_error      = (r_state == S_DONE) && r_err;
    end

    // Request latch on accept, response capture on the selected ack; error responses carry zero data.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_port_cycle <= '0;
            r_paddr      <= '0;
            r_access     <= '0;
            r_data_out   <= '0;
            r_sel        <= '0;
            r_err        <= 1'b0;
            r_data       <= '0;
        end else begin
            r_port_cycle <= w_port_cycle_nxt;
            if (w_accept) begin
                r_paddr    <= i_mem_paddr;
                r_access   <= i_mem_access;
                r_data_out <= i_mem_data_out;
                r_sel      <= w_hit_sel;
                r_err      <= !w_hit;
                r_data     <= '0;
            end
            if (w_capture) begin
                r_data <= w_sel_data;
                r_err  <= 1'b0;
            end else if (w_expire) begin
                r_err  <= 1'b1;
            end
        end
    end

    assign o_mem_data_in   = r_data;
    assign o_port_cycle    = r_port_cycle;
    assign o_port_paddr    = {NUM_PORTS{r_paddr}};
    assign o_port_access   = {NUM_PORTS{r_access}};
    assign o_port_data_out = {NUM_PORTS{r_data_out}};

endmodule

// File: tb/tb_bus_router.sv
// tb_bus_router: randomized scoreboard bench for bus_router against a window-decode reference model.
`ifndef PLEN
`define PLEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
`timescale 1ns/1ps

module tb_bus_router;
    localparam int NP = 3;
    localparam int T  = 8;
    localparam int DW = 4 * `XLEN;
`ifdef BUS_ROUTER_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    // port0: upper half, port1: lowest quarter, port2: fully shadowed by port0, 0x4..0x7 unmapped
    localparam logic [31:0] WBASE [NP] = '{32'h8000_0000, 32'h0000_0000, 32'hF000_0000};
    localparam logic [31:0] WMASK [NP] = '{32'h8000_0000, 32'hC000_0000, 32'hF000_0000};

    typedef struct {
        logic          err;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic                            clk = 1'b0;
    logic                            rst = 1'b1;
    logic                            mem_cycle = 1'b0;
    logic [31:0]                     mem_paddr = '0;
    logic [31:0]                     mem_data_out = '0;
    execute::memory_access_t         mem_access = '0;
    logic [DW-1:0]                   mem_data_in;
    logic                            mem_ack;
    logic                            mem_error;
    logic [NP-1:0]                   port_cycle;
    logic [NP*32-1:0]                port_paddr;
    execute::memory_access_t [NP-1:0] port_access;
    logic [NP*32-1:0]                port_data_out;
    logic [NP*DW-1:0]                port_data_in = '0;
    logic [NP-1:0]                   port_ack = '0;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_run = 0;
    int            n_fail = 0;
    int            cyc = 0;
    logic [NP-1:0] exp_pc = '0;
    logic [31:0]   cur_addr = '0;
    logic [31:0]   cur_data = '0;
    logic [4:0]    cur_acc = '0;

    bus_router #(
        .NUM_PORTS      (NP),
        .BASE_ADDRS     ({32'hF000_0000, 32'h0000_0000, 32'h8000_0000}),
        .ADDR_MASKS     ({32'hF000_0000, 32'hC000_0000, 32'h8000_0000}),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_mem_cycle     (mem_cycle),
        .i_mem_paddr     (mem_paddr),
        .i_mem_access    (mem_access),
        .i_mem_data_out  (mem_data_out),
        .o_mem_data_in   (mem_data_in),
        .o_mem_ack       (mem_ack),
        .o_mem_error     (mem_error),
        .o_port_cycle    (port_cycle),
        .o_port_paddr    (port_paddr),
        .o_port_access   (port_access),
        .o_port_data_out (port_data_out),
        .i_port_data_in  (port_data_in),
        .i_port_ack      (port_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference decode: first window (in port order) whose masked bits equal its base, else unmapped.
    function automatic int route(input logic [31:0] a);
        for (int p = 0; p < NP; p++)
            if ((a & WMASK[p]) == WBASE[p]) return p;
        return -1;
    endfunction

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: per-cycle port_cycle/broadcast checks and scoreboard pop on every completion.
    always @(negedge clk) begin
        chk("port_cycle", DW'(port_cycle), DW'(exp_pc));
        if (port_cycle != '0) begin
            for (int p = 0; p < NP; p++) begin
                chk("port_paddr", DW'(port_paddr[p*32 +: 32]), DW'(cur_addr));
                chk("port_data_out", DW'(port_data_out[p*32 +: 32]), DW'(cur_data));
                chk("port_access", DW'(port_access[p]), DW'(cur_acc));
            end
        end
        if (mem_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", DW'(1), DW'(0));
            end else begin
                mon_e = sb.pop_front();
                chk("mem_error", DW'(mem_error), DW'(mon_e.err));
                chk("mem_data_in", mem_data_in, mon_e.data);
                chk("ack_cycle", DW'(cyc), DW'(mon_e.cyc));
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_port_cycle"}, DW'(port_cycle), '0);
        chk({tag, "_mem_ack"}, DW'(mem_ack), '0);
        chk({tag, "_mem_error"}, DW'(mem_error), '0);
        chk({tag, "_mem_data_in"}, mem_data_in, '0);
        chk({tag, "_port_paddr"}, DW'(port_paddr), '0);
        chk({tag, "_port_access"}, DW'(port_access), '0);
        chk({tag, "_port_data_out"}, DW'(port_data_out), '0);
    endtask

    // One CPU transaction; d is the number of cycles the selected port waits before acking.
    task automatic transact(input logic [31:0] addr, input logic [31:0] wdata, input int d,
                            input bit fixed, input logic [DW-1:0] pd);
        int         p = route(addr);
        bit         tmo = TMO && (p >= 0) && (d >= T);
        logic [4:0] a = 5'($urandom);
        exp_t       e;
        @(negedge clk);
        for (int q = 0; q < NP; q++)
            port_data_in[q*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        if (fixed && p >= 0) port_data_in[p*DW +: DW] = pd;
        mem_paddr    = addr;
        mem_data_out = wdata;
        mem_access   = a;
        mem_cycle    = 1'b1;
        cur_addr     = addr;
        cur_data     = wdata;
        cur_acc      = a;
        e.err        = (p < 0) || tmo;
        e.data       = '0;
        if (!e.err) e.data = port_data_in[p*DW +: DW];
        e.cyc        = (p < 0) ? cyc + 1 : tmo ? cyc + 1 + T : cyc + 2 + d;
        sb.push_back(e);
        @(posedge clk);
        if (p >= 0) begin
            exp_pc = NP'(1) << p;
            for (int i = 0; i < (tmo ? T : d + 1); i++) begin
                @(negedge clk);
                port_ack = NP'($urandom) & ~(NP'(1) << p);
                if (!tmo && i == d) port_ack[p] = 1'b1;
            end
            @(posedge clk);
            exp_pc = '0;
        end
        @(negedge clk);
        port_ack = '0;
        for (int i = 0; i < 4 && !mem_ack; i++) @(negedge clk);
        if (!mem_ack) chk("ack_wait", DW'(0), DW'(1));
        mem_cycle = 1'b0;
    endtask

    // Reset while a hit transaction is waiting: no completion may follow, late acks are ignored.
    task automatic reset_in_busy(input logic [31:0] addr);
        @(negedge clk);
        mem_paddr    = addr;
        mem_data_out = 32'hCAFE_F00D;
        mem_access   = '0;
        mem_cycle    = 1'b1;
        cur_addr     = addr;
        cur_data     = 32'hCAFE_F00D;
        cur_acc      = '0;
        @(posedge clk);
        exp_pc = NP'(1) << route(addr);
        repeat (2) @(negedge clk);
        rst       = 1'b1;
        mem_cycle = 1'b0;
        @(posedge clk);
        exp_pc = '0;
        @(negedge clk);
        chk_reset("mid_reset");
        rst      = 1'b0;
        port_ack = '1;
        @(negedge clk);
        port_ack = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        repeat (2) @(negedge clk);
        chk_reset("por");
        rst = 1'b0;
        transact(32'h8000_0040, 32'h0, 2, 1'b1, {4{32'hDEAD_BEEF}});
        transact(32'h1000_0000, 32'h1234_5678, 1, 1'b0, '0);
        transact(32'hF000_0000, 32'h5555_AAAA, 0, 1'b0, '0);
        transact(32'h4000_0010, 32'h0BAD_0BAD, 0, 1'b0, '0);
        transact(32'h8000_0000, 32'h1, 0, 1'b0, '0);
        transact(32'h3FFF_FFFC, 32'h2, 0, 1'b0, '0);
`ifdef BUS_ROUTER_TIMEOUT_EN
        transact(32'h8000_0100, 32'h3, T, 1'b0, '0);
        @(negedge clk);
        port_ack = 3'b001;
        @(negedge clk);
        port_ack = '0;
        transact(32'h8000_0200, 32'h4, T - 1, 1'b0, '0);
`else
        transact(32'h0000_0200, 32'h4, 20, 1'b0, '0);
`endif
        reset_in_busy(32'h8000_1000);
        transact(32'h2000_0000, 32'h5, 0, 1'b0, '0);
        for (int n = 0; n < 60; n++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000 | r;
                1:       a = r & 32'h3FFF_FFFF;
                2:       a = 32'h4000_0000 | (r & 32'h3FFF_FFFF);
                default: a = 32'hF000_0000 | r;
            endcase
            transact(a, $urandom, $urandom_range(0, TMO ? T - 1 : 6), 1'b0, '0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", DW'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
